// File: rtl/bcd_serial_converter.sv
// Binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock.
// start/busy/done handshake; bcd_out and overflow hold until the next conversion finishes.
module bcd_serial_converter #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int ACC_W = 4 * DIGITS;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Each digit >= 5 gets +3; the result is at most 12, so digits never carry into each other.
    function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int k = 0; k < DIGITS; k++) begin
            if (a[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = a[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = a[4*k +: 4];
            end
        end
        return r;
    endfunction

    state_t               state_r, state_s;
    logic [BIN_WIDTH-1:0] bin_sr_r, bin_sr_s;
    logic [ACC_W-1:0]     acc_r, acc_s;
    logic                 ovf_acc_r, ovf_acc_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic [ACC_W-1:0]     bcd_r, bcd_s;
    logic                 overflow_r, overflow_s;

    logic [ACC_W-1:0]     adj_s;
    logic [ACC_W-1:0]     acc_shift_s;
    logic                 carry_s;
    logic                 last_shift_s;

    assign adj_s        = dabble_adjust(acc_r);
    assign carry_s      = adj_s[ACC_W-1];
    assign acc_shift_s  = {adj_s[ACC_W-2:0], bin_sr_r[BIN_WIDTH-1]};
    assign last_shift_s = (cnt_r == CNT_W'(BIN_WIDTH - 1));

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            bin_sr_r   <= {BIN_WIDTH{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            ovf_acc_r  <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= {ACC_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            bin_sr_r   <= bin_sr_s;
            acc_r      <= acc_s;
            ovf_acc_r  <= ovf_acc_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            bcd_r      <= bcd_s;
            overflow_r <= overflow_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered-output next values; done defaults low so it is a single-cycle pulse.
    always_comb begin
        bin_sr_s   = bin_sr_r;
        acc_s      = acc_r;
        ovf_acc_s  = ovf_acc_r;
        cnt_s      = cnt_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        bcd_s      = bcd_r;
        overflow_s = overflow_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    bin_sr_s  = bin_in;
                    acc_s     = {ACC_W{1'b0}};
                    ovf_acc_s = 1'b0;
                    cnt_s     = {CNT_W{1'b0}};
                    busy_s    = 1'b1;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            SHIFT: begin
                bin_sr_s  = {bin_sr_r[BIN_WIDTH-2:0], 1'b0};
                acc_s     = acc_shift_s;
                ovf_acc_s = ovf_acc_r | carry_s;
                cnt_s     = cnt_r + CNT_W'(1);
                if (last_shift_s) begin
                    bcd_s      = acc_shift_s;
                    overflow_s = ovf_acc_r | carry_s;
                    done_s     = 1'b1;
                    busy_s     = 1'b0;
                end else begin
                    busy_s     = 1'b1;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd_out  = bcd_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed bench for bcd_serial_converter: a 5-digit and a 4-digit instance share the stimulus.
module tb_bcd_serial_converter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    bcd_serial_converter #(.BIN_WIDTH(16), .DIGITS(5)) u_dut5 (
        .clock(clock), .reset_n(reset_n), .start(start), .bin_in(bin_in),
        .busy(busy5), .done(done5), .bcd_out(bcd5), .overflow(ovf5)
    );

    bcd_serial_converter #(.BIN_WIDTH(16), .DIGITS(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .start(start), .bin_in(bin_in),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts a conversion at a negedge in IDLE; returns at the negedge where done is seen.
    task automatic convert(input logic [15:0] v,
                           output logic [19:0] r5, output logic o5,
                           output logic [15:0] r4, output logic o4,
                           output int lat, output int bcnt);
        start  = 1'b1;
        bin_in = v;
        @(negedge clock);
        start  = 1'b0;
        bin_in = 16'hA5A5;
        lat  = -1;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done5) begin
                lat = i;
                break;
            end
            if (busy5) bcnt++;
            @(negedge clock);
        end
        r5 = bcd5;
        o5 = ovf5;
        r4 = bcd4;
        o4 = ovf4;
    endtask

    initial begin
        logic [19:0] r5, b1, b2;
        logic [15:0] r4;
        logic        o5, o4;
        int          lat, bcnt, t1, t2, pulses;

        vecs[0] = '{16'd0,     20'h00000, 1'b0};
        vecs[1] = '{16'd1234,  20'h01234, 1'b0};
        vecs[2] = '{16'd65535, 20'h65535, 1'b0};
        vecs[3] = '{16'd9,     20'h00009, 1'b0};
        vecs[4] = '{16'd10,    20'h00010, 1'b0};
        vecs[5] = '{16'd99,    20'h00099, 1'b0};
        vecs[6] = '{16'd100,   20'h00100, 1'b0};
        vecs[7] = '{16'd4096,  20'h04096, 1'b0};
        vecs[8] = '{16'd59999, 20'h59999, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        bin_in  = 16'd0;
        @(negedge clock);
        check("reset_busy", busy5, 1'b0);
        check("reset_done", done5, 1'b0);
        check("reset_bcd", bcd5, 20'h00000);
        check("reset_ovf", ovf5, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);

        // Table-driven conversions on the 5-digit instance.
        for (int n = 0; n < 9; n++) begin
            convert(vecs[n].bin, r5, o5, r4, o4, lat, bcnt);
            check($sformatf("bcd[%0d]", vecs[n].bin), r5, vecs[n].bcd);
            check($sformatf("ovf[%0d]", vecs[n].bin), o5, vecs[n].ovf);
            check($sformatf("latency[%0d]", vecs[n].bin), lat, 16);
            check($sformatf("busy_cycles[%0d]", vecs[n].bin), bcnt, 16);
            @(negedge clock);
            check($sformatf("done_pulse_width[%0d]", vecs[n].bin), done5, 1'b0);
        end

        // start held high: 9 then 10, back to back.
        start  = 1'b1;
        bin_in = 16'd9;
        @(negedge clock);
        bin_in = 16'd10;
        t1 = -1; t2 = -1; b1 = '0; b2 = '0;
        for (int i = 0; i < 60; i++) begin
            if (done5) begin
                if (t1 < 0) begin
                    t1 = i;
                    b1 = bcd5;
                end else begin
                    t2 = i;
                    b2 = bcd5;
                    start = 1'b0;
                    break;
                end
            end
            @(negedge clock);
        end
        start = 1'b0;
        check("b2b_spacing", t2 - t1, 17);
        check("b2b_first", b1, 20'h00009);
        check("b2b_second", b2, 20'h00010);
        @(negedge clock);
        @(negedge clock);

        // start during SHIFT is ignored.
        start  = 1'b1;
        bin_in = 16'd1234;
        @(negedge clock);
        start = 1'b0;
        check("hold_during_shift", bcd5, 20'h00010);
        repeat (5) @(negedge clock);
        start  = 1'b1;
        bin_in = 16'd4321;
        @(negedge clock);
        start  = 1'b0;
        pulses = 0;
        b1     = '0;
        for (int i = 0; i < 50; i++) begin
            if (done5) begin
                pulses++;
                b1 = bcd5;
            end
            @(negedge clock);
        end
        check("ignored_start_pulses", pulses, 1);
        check("ignored_start_result", b1, 20'h01234);

        // Reset mid-conversion.
        start  = 1'b1;
        bin_in = 16'd65535;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        check("busy_before_reset", busy5, 1'b1);
        check("bcd_before_reset", bcd5, 20'h01234);
        reset_n = 1'b0;
        #1;
        check("midreset_busy", busy5, 1'b0);
        check("midreset_bcd", bcd5, 20'h00000);
        check("midreset_done", done5, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 40; i++) begin
            if (done5) pulses++;
            @(negedge clock);
        end
        check("no_done_after_reset", pulses, 0);

        // 4-digit instance overflow boundary.
        convert(16'd10000, r5, o5, r4, o4, lat, bcnt);
        check("d4_ovf_10000", o4, 1'b1);
        check("d4_done_with_ovf", done4, 1'b1);
        check("d5_bcd_10000", r5, 20'h10000);
        @(negedge clock);
        convert(16'd9999, r5, o5, r4, o4, lat, bcnt);
        check("d4_bcd_9999", r4, 16'h9999);
        check("d4_ovf_9999", o4, 1'b0);
        @(negedge clock);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
